id_ex_stage: RTL
================

Name: id_ex_stage

Overview:
- Registers the decoded instruction from ID into EX for the RV32I 5-stage pipeline.
- Detects load-use hazards and injects bubbles into EX.
- Handles branch-taken flushes and global hold.
- Its outputs (rs1_ex_o, rs2_ex_o, rd_ex_o, ctrl RUWr) feed the EX operand muxes and the forwarding unit, so it must guarantee clean, x0-safe register tags.

Parameters:
XLEN, 32, datapath width
ALUOP_W, 4, ALU operation code width

Ports:
clk  in  1  rising-edge clock
rst_n  in  1  reset; synchronous, active-low
hold_i  in  1  global freeze (e.g. data memory busy); all state held
br_taken_ex_i  in  1  branch/jump in EX resolved taken
valid_id_i  in  1  ID holds a real instruction
pc_id_i  in  XLEN  PC of ID instruction
rs1_id_i  in  5  source register 1 index
rs2_id_i  in  5  source register 2 index
rd_id_i  in  5  destination register index
use_rs1_id_i  in  1  instruction actually reads rs1
use_rs2_id_i  in  1  instruction actually reads rs2
rs1_data_id_i  in  XLEN  register-file read data 1
rs2_data_id_i  in  XLEN  register-file read data 2
imm_id_i  in  XLEN  decoded immediate
ctrl_id_i  in  ctrl_t  packed control: RUWr, DMRd, DMWr, ALUOp[ALUOP_W], ALUASrc, ALUBSrc, RUDataWrSrc[2], BrOp[5]
valid_ex_o  out  1  EX holds a real instruction
pc_ex_o, rs1_data_ex_o, rs2_data_ex_o, imm_ex_o  out  XLEN  registered copies
rs1_ex_o, rs2_ex_o, rd_ex_o  out  5  registered register tags
ctrl_ex_o  out  ctrl_t  registered control
stall_ifid_o  out  1  hold PC and IF/ID register this cycle
flush_ifid_o  out  1  squash IF/ID contents at next edge

Behaviour:
- Reset (rst_n=0 at edge): valid_ex_o=0, ctrl_ex_o=CTRL_BUBBLE, all tags, PC and data fields = 0.
- Latency is one cycle, ID to EX.
- load_use = valid_id_i & valid_ex_o & ctrl_ex_o.DMRd & (rd_ex_o!=0) & ((use_rs1_id_i & rs1_id_i==rd_ex_o) | (use_rs2_id_i & rs2_id_i==rd_ex_o)).
- Edge priority:
  - reset
  - hold_i: all registers keep their value
  - br_taken_ex_i: insert bubble
  - load_use: insert bubble
  - otherwise: capture ID
- Bubble: valid_ex_o=0, ctrl_ex_o=CTRL_BUBBLE (RUWr=DMRd=DMWr=0, BrOp=BROP_NONE), tags = 0, data = 0.
- Capture: all fields copied from ID. valid_ex_o=valid_id_i. Stored RUWr = ctrl_id_i.RUWr & valid_id_i & (rd_id_i!=0). This keeps downstream forwarding from matching x0 or invalid slots.
- Combinational outputs:
  - stall_ifid_o = hold_i | (load_use & ~br_taken_ex_i)
  - flush_ifid_o = br_taken_ex_i & ~hold_i
- Flush wins over load_use, because the stalled ID instruction is on the wrong path anyway.
- A load-use stall lasts exactly one cycle: after the bubble, EX holds no load.
- Back-to-back load-use (load followed by a dependent load) stalls once per pair.
- hold_i concurrent with br_taken_ex_i: nothing flushes. The branch stays in EX and re-asserts after the hold releases.
- rd_ex_o=0 with DMRd never stalls.
- A dependency through an unused field (use_rsX=0) never stalls.
- rst_n low mid-stall: the reset state is taken at that edge. The stall outputs then evaluate from the reset state (stall_ifid_o=hold_i, flush from br_taken_ex_i).

Optional Feature:
- Macro: HAZARD_STATS_EN.
- When defined, adds two 32-bit output ports:
  - stall_cnt_o: counts edges where a load-use bubble was inserted.
  - flush_cnt_o: counts edges where a flush bubble was inserted.
- Both counters saturate at 0xFFFFFFFF, reset to 0, and do not count hold_i cycles.
- When undefined, the ports and counters are absent and there is no logic overhead.

Decomposition:
- Package pipe_pkg holds: ctrl_t packed struct, CTRL_BUBBLE constant, BROP_NONE, XLEN default.
- Sub-module load_use_detect (combinational): computes load_use from ID tags and EX state. It is reused later by the decode stall logic.

Test Plan:
- Reset: drive rst_n=0 with random ID inputs -> valid_ex_o=0, ctrl_ex_o=CTRL_BUBBLE, stall_ifid_o=0, flush_ifid_o=0.
- ID: add x3,x1,x2, then next cycle EX shows rs1_ex_o=1, rs2_ex_o=2, rd_ex_o=3, RUWr=1. Repeat with rd=0 -> RUWr=0.
- lw x5,0(x1) in EX with add x6,x5,x7 in ID -> stall_ifid_o=1 for exactly 1 cycle, EX gets a bubble. Next cycle add is in EX with rs1_ex_o=5.
- beq taken in EX (br_taken_ex_i=1) while ID has a load-use dependency -> flush_ifid_o=1, stall_ifid_o=0, EX bubble next cycle.
- hold_i=1 for 3 cycles during load-use -> EX fields unchanged, stall_ifid_o=1. After release, one bubble, then the dependent instruction proceeds.
- HAZARD_STATS_EN: 2 load-use stalls + 1 flush -> stall_cnt_o=2, flush_cnt_o=1. Counters preloaded near 0xFFFFFFFF saturate.

Source files
------------

// File: rtl/pipe_pkg.sv
// Shared pipeline types: packed EX control word, bubble constant and datapath defaults.
package pipe_pkg;

    localparam int unsigned XLEN_DEFAULT = 32;
    localparam int unsigned ALUOP_W      = 4;
    localparam int unsigned BROP_W       = 5;
    localparam int unsigned REG_W        = 5;
    localparam int unsigned CNT_W        = 32;

    localparam logic [BROP_W-1:0] BROP_NONE = 5'b00000;

    typedef struct packed {
        logic               ru_wr;
        logic               dm_rd;
        logic               dm_wr;
        logic [ALUOP_W-1:0] alu_op;
        logic               alu_a_src;
        logic               alu_b_src;
        logic [1:0]         ru_data_wr_src;
        logic [BROP_W-1:0]  br_op;
    } ctrl_t;

    localparam ctrl_t CTRL_BUBBLE = '{
        ru_wr:          1'b0,
        dm_rd:          1'b0,
        dm_wr:          1'b0,
        alu_op:         '0,
        alu_a_src:      1'b0,
        alu_b_src:      1'b0,
        ru_data_wr_src: 2'b00,
        br_op:          BROP_NONE
    };

endpackage

// File: rtl/load_use_detect.sv
// Combinational load-use hazard check between the ID instruction and a load sitting in EX.
import pipe_pkg::*;

module load_use_detect (
    input  logic             valid_id_i,
    input  logic [REG_W-1:0] rs1_id_i,
    input  logic [REG_W-1:0] rs2_id_i,
    input  logic             use_rs1_id_i,
    input  logic             use_rs2_id_i,
    input  logic             valid_ex_i,
    input  logic             dm_rd_ex_i,
    input  logic [REG_W-1:0] rd_ex_i,
    output logic             load_use_c
);

    logic rs1_hit;
    logic rs2_hit;

    // x0 is never a real producer, so a load targeting it cannot create a dependency
    always_comb begin
        rs1_hit    = use_rs1_id_i & (rs1_id_i == rd_ex_i);
        rs2_hit    = use_rs2_id_i & (rs2_id_i == rd_ex_i);
        load_use_c = valid_id_i & valid_ex_i & dm_rd_ex_i & (rd_ex_i != '0) & (rs1_hit | rs2_hit);
    end

endmodule

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register with load-use bubble insertion, branch flush and global hold.
// Optional hazard counters (stall_cnt_o, flush_cnt_o) are built when HAZARD_STATS_EN is defined.
import pipe_pkg::*;

module id_ex_stage #(
    parameter int unsigned XLEN = XLEN_DEFAULT
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             hold_i,
    input  logic             br_taken_ex_i,
    input  logic             valid_id_i,
    input  logic [XLEN-1:0]  pc_id_i,
    input  logic [REG_W-1:0] rs1_id_i,
    input  logic [REG_W-1:0] rs2_id_i,
    input  logic [REG_W-1:0] rd_id_i,
    input  logic             use_rs1_id_i,
    input  logic             use_rs2_id_i,
    input  logic [XLEN-1:0]  rs1_data_id_i,
    input  logic [XLEN-1:0]  rs2_data_id_i,
    input  logic [XLEN-1:0]  imm_id_i,
    input  ctrl_t            ctrl_id_i,
    output logic             valid_ex_o,
    output logic [XLEN-1:0]  pc_ex_o,
    output logic [XLEN-1:0]  rs1_data_ex_o,
    output logic [XLEN-1:0]  rs2_data_ex_o,
    output logic [XLEN-1:0]  imm_ex_o,
    output logic [REG_W-1:0] rs1_ex_o,
    output logic [REG_W-1:0] rs2_ex_o,
    output logic [REG_W-1:0] rd_ex_o,
    output ctrl_t            ctrl_ex_o,
`ifdef HAZARD_STATS_EN
    output logic [CNT_W-1:0] stall_cnt_o,
    output logic [CNT_W-1:0] flush_cnt_o,
`endif
    output logic             stall_ifid_o,
    output logic             flush_ifid_o
);

    logic             valid_q,    valid_d;
    logic [XLEN-1:0]  pc_q,       pc_d;
    logic [XLEN-1:0]  rs1_data_q, rs1_data_d;
    logic [XLEN-1:0]  rs2_data_q, rs2_data_d;
    logic [XLEN-1:0]  imm_q,      imm_d;
    logic [REG_W-1:0] rs1_q,      rs1_d;
    logic [REG_W-1:0] rs2_q,      rs2_d;
    logic [REG_W-1:0] rd_q,       rd_d;
    ctrl_t            ctrl_q,     ctrl_d;
    logic             load_use_c;
    logic             bubble_c;

    load_use_detect u_load_use_detect (
        .valid_id_i   (valid_id_i),
        .rs1_id_i     (rs1_id_i),
        .rs2_id_i     (rs2_id_i),
        .use_rs1_id_i (use_rs1_id_i),
        .use_rs2_id_i (use_rs2_id_i),
        .valid_ex_i   (valid_q),
        .dm_rd_ex_i   (ctrl_q.dm_rd),
        .rd_ex_i      (rd_q),
        .load_use_c   (load_use_c)
    );

    // Next EX contents: hold > flush bubble > load-use bubble > capture
    always_comb begin
        valid_d    = valid_q;
        pc_d       = pc_q;
        rs1_data_d = rs1_data_q;
        rs2_data_d = rs2_data_q;
        imm_d      = imm_q;
        rs1_d      = rs1_q;
        rs2_d      = rs2_q;
        rd_d       = rd_q;
        ctrl_d     = ctrl_q;
        bubble_c   = br_taken_ex_i | load_use_c;
        if (!hold_i) begin
            if (bubble_c) begin
                valid_d    = 1'b0;
                pc_d       = '0;
                rs1_data_d = '0;
                rs2_data_d = '0;
                imm_d      = '0;
                rs1_d      = '0;
                rs2_d      = '0;
                rd_d       = '0;
                ctrl_d     = CTRL_BUBBLE;
            end else begin
                valid_d    = valid_id_i;
                pc_d       = pc_id_i;
                rs1_data_d = rs1_data_id_i;
                rs2_data_d = rs2_data_id_i;
                imm_d      = imm_id_i;
                rs1_d      = rs1_id_i;
                rs2_d      = rs2_id_i;
                rd_d       = rd_id_i;
                ctrl_d     = ctrl_id_i;
                // Forwarding must never match x0 or an empty slot
                ctrl_d.ru_wr = ctrl_id_i.ru_wr & valid_id_i & (rd_id_i != '0);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            valid_q    <= 1'b0;
            pc_q       <= '0;
            rs1_data_q <= '0;
            rs2_data_q <= '0;
            imm_q      <= '0;
            rs1_q      <= '0;
            rs2_q      <= '0;
            rd_q       <= '0;
            ctrl_q     <= CTRL_BUBBLE;
        end else begin
            valid_q    <= valid_d;
            pc_q       <= pc_d;
            rs1_data_q <= rs1_data_d;
            rs2_data_q <= rs2_data_d;
            imm_q      <= imm_d;
            rs1_q      <= rs1_d;
            rs2_q      <= rs2_d;
            rd_q       <= rd_d;
            ctrl_q     <= ctrl_d;
        end
    end

    // A taken branch makes the stalled ID instruction irrelevant, so flush wins
    always_comb begin
        stall_ifid_o = hold_i | (load_use_c & ~br_taken_ex_i);
        flush_ifid_o = br_taken_ex_i & ~hold_i;
    end

    assign valid_ex_o    = valid_q;
    assign pc_ex_o       = pc_q;
    assign rs1_data_ex_o = rs1_data_q;
    assign rs2_data_ex_o = rs2_data_q;
    assign imm_ex_o      = imm_q;
    assign rs1_ex_o      = rs1_q;
    assign rs2_ex_o      = rs2_q;
    assign rd_ex_o       = rd_q;
    assign ctrl_ex_o     = ctrl_q;

`ifdef HAZARD_STATS_EN
    logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;
    logic [CNT_W-1:0] flush_cnt_q, flush_cnt_d;

    // Saturating event counters, frozen while held
    always_comb begin
        stall_cnt_d = stall_cnt_q;
        flush_cnt_d = flush_cnt_q;
        if (!hold_i && br_taken_ex_i && (flush_cnt_q != '1)) begin
            flush_cnt_d = flush_cnt_q + CNT_W'(1);
        end
        if (!hold_i && !br_taken_ex_i && load_use_c && (stall_cnt_q != '1)) begin
            stall_cnt_d = stall_cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            stall_cnt_q <= '0;
            flush_cnt_q <= '0;
        end else begin
            stall_cnt_q <= stall_cnt_d;
            flush_cnt_q <= flush_cnt_d;
        end
    end

    assign stall_cnt_o = stall_cnt_q;
    assign flush_cnt_o = flush_cnt_q;
`endif

endmodule
